// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C master engine between NUM_REQ requesters.
// Define I2C_ARB_AUTOPOLL_EN to add an internal lowest-priority periodic read of address 7'h49.
module i2c_txn_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4095,
   parameter int unsigned POLL_PERIOD    = 800000
) (
   input  logic                    I2C_clock,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [7*NUM_REQ-1:0]    req_addr,
   input  logic [NUM_REQ-1:0]      req_rw,
   input  logic [16*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]      done,
   output logic [NUM_REQ-1:0]      err,
   output logic [15:0]             rd_data,
   output logic                    m_ena,
   output logic [6:0]              m_addr,
   output logic                    m_rw,
   output logic [15:0]             m_data_wr,
   input  logic                    m_busy,
   input  logic [15:0]             m_data_rd,
   output logic                    arb_busy
`ifdef I2C_ARB_AUTOPOLL_EN
   ,
   output logic [15:0]             poll_data,
   output logic                    poll_valid
`endif
);

   localparam int unsigned RW   = $clog2(NUM_REQ);
   localparam int unsigned TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || POLL_PERIOD < 1) begin : g_bad_param
      $error("i2c_txn_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_DONE,
      S_GAP
   } state_t;

   state_t              state;
   logic [RW-1:0]       rr_ptr;
   logic [RW-1:0]       g_idx;
   logic                g_rw;
   logic [TW-1:0]       timer;
   logic                seen_low;
   logic                pick_vld;
   logic [RW-1:0]       pick_j;
   logic [RW-1:0]       cand;
   logic [NUM_REQ-1:0]  fin_onehot;
   logic [6:0]          addr_a [NUM_REQ];
   logic [15:0]         data_a [NUM_REQ];

`ifdef I2C_ARB_AUTOPOLL_EN
   localparam int unsigned PW        = $clog2(POLL_PERIOD + 1);
   localparam logic [6:0]  POLL_ADDR = 7'h49;
   logic          g_poll;
   logic          poll_pend;
   logic [PW-1:0] poll_timer;
`endif

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i] = req_addr[7*i +: 7];
      assign data_a[i] = req_data[16*i +: 16];
   end

   // Round-robin pick: first requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_vld = 1'b0;
      pick_j   = '0;
      cand     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = RW'((32'(rr_ptr) + k) % NUM_REQ);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_j   = cand;
         end
      end
   end

   always_comb begin
      fin_onehot = NUM_REQ'(1) << g_idx;
`ifdef I2C_ARB_AUTOPOLL_EN
      if (g_poll) fin_onehot = '0;
`endif
   end

   always_ff @(posedge I2C_clock) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         g_idx     <= '0;
         g_rw      <= 1'b0;
         timer     <= '0;
         seen_low  <= 1'b0;
         done      <= '0;
         err       <= '0;
         rd_data   <= '0;
         m_ena     <= 1'b0;
         m_addr    <= '0;
         m_rw      <= 1'b0;
         m_data_wr <= '0;
         arb_busy  <= 1'b0;
`ifdef I2C_ARB_AUTOPOLL_EN
         g_poll     <= 1'b0;
         poll_pend  <= 1'b0;
         poll_timer <= '0;
         poll_data  <= '0;
         poll_valid <= 1'b0;
`endif
      end else begin
         done <= '0;
         err  <= '0;
`ifdef I2C_ARB_AUTOPOLL_EN
         poll_valid <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  g_idx     <= pick_j;
                  g_rw      <= req_rw[pick_j];
                  m_addr    <= addr_a[pick_j];
                  m_rw      <= req_rw[pick_j];
                  m_data_wr <= data_a[pick_j];
                  rr_ptr    <= (pick_j == RW'(NUM_REQ - 1)) ? '0 : pick_j + 1'b1;
                  m_ena     <= 1'b1;
                  timer     <= '0;
                  seen_low  <= 1'b0;
                  arb_busy  <= 1'b1;
                  state     <= S_LAUNCH;
`ifdef I2C_ARB_AUTOPOLL_EN
                  g_poll    <= 1'b0;
               end else if (poll_pend) begin
                  g_poll    <= 1'b1;
                  poll_pend <= 1'b0;
                  g_rw      <= 1'b1;
                  m_addr    <= POLL_ADDR;
                  m_rw      <= 1'b1;
                  m_data_wr <= '0;
                  m_ena     <= 1'b1;
                  timer     <= '0;
                  seen_low  <= 1'b0;
                  arb_busy  <= 1'b1;
                  state     <= S_LAUNCH;
`endif
               end
            end
            // Busy may still be high from a draining transaction; require a low first.
            S_LAUNCH: begin
               if (seen_low && m_busy) begin
                  m_ena <= 1'b0;
                  timer <= '0;
                  state <= S_RUN;
               end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  m_ena <= 1'b0;
                  done  <= fin_onehot;
                  err   <= fin_onehot;
                  state <= S_DONE;
               end else begin
                  timer <= timer + 1'b1;
                  if (!m_busy) seen_low <= 1'b1;
               end
            end
            S_RUN: begin
               if (!m_busy) begin
                  done <= fin_onehot;
`ifdef I2C_ARB_AUTOPOLL_EN
                  if (g_poll) begin
                     poll_data  <= m_data_rd;
                     poll_valid <= 1'b1;
                  end else if (g_rw) begin
                     rd_data <= m_data_rd;
                  end
`else
                  if (g_rw) rd_data <= m_data_rd;
`endif
                  state <= S_DONE;
               end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  done  <= fin_onehot;
                  err   <= fin_onehot;
                  state <= S_DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DONE: begin
               timer <= '0;
               state <= S_GAP;
            end
            S_GAP: begin
               if (timer == TW'(GAP_CYCLES - 1)) begin
                  arb_busy <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               m_ena    <= 1'b0;
               arb_busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
`ifdef I2C_ARB_AUTOPOLL_EN
         // A period expiring while a poll is pending just keeps it pending.
         if (poll_timer == PW'(POLL_PERIOD - 1)) begin
            poll_timer <= '0;
            poll_pend  <= 1'b1;
         end else begin
            poll_timer <= poll_timer + 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: stimulus queues expected launches/completions, a monitor compares.
module tb_i2c_txn_arbiter;

   localparam int unsigned NR  = 4;
   localparam int unsigned GAP = 16;
   localparam int unsigned TMO = 4095;

   localparam logic [6:0]  ADDR [4] = '{7'h21, 7'h10, 7'h3A, 7'h4C};
   localparam logic [15:0] DATA [4] = '{16'hA55A, 16'h5555, 16'h0BAD, 16'h1111};

   typedef struct { logic [6:0] addr; logic rw; logic [15:0] data; } launch_t;
   typedef struct { int idx; logic er; logic [15:0] rd; } done_t;
   typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

   logic              I2C_clock = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req;
   logic [7*NR-1:0]   req_addr;
   logic [NR-1:0]     req_rw;
   logic [16*NR-1:0]  req_data;
   logic [NR-1:0]     done;
   logic [NR-1:0]     err;
   logic [15:0]       rd_data;
   logic              m_ena;
   logic [6:0]        m_addr;
   logic              m_rw;
   logic [15:0]       m_data_wr;
   logic              m_busy;
   logic [15:0]       m_data_rd;
   logic              arb_busy;
`ifdef I2C_ARB_AUTOPOLL_EN
   logic [15:0]       poll_data;
   logic              poll_valid;
`endif

   launch_t launch_q[$];
   done_t   done_q[$];
   chk_t    chk_q[$];
   int      checks = 0;
   int      passes = 0;

   int          rise_dly;
   int          run_len;
   logic [15:0] rd_val;
   bit          hang;

   always #5 I2C_clock = ~I2C_clock;

   i2c_txn_arbiter #(
      .NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .POLL_PERIOD(1000)
   ) dut (
      .I2C_clock(I2C_clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
      .req_rw(req_rw), .req_data(req_data), .done(done), .err(err), .rd_data(rd_data),
      .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw), .m_data_wr(m_data_wr),
      .m_busy(m_busy), .m_data_rd(m_data_rd), .arb_busy(arb_busy)
`ifdef I2C_ARB_AUTOPOLL_EN
      , .poll_data(poll_data), .poll_valid(poll_valid)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Engine model: raise busy rise_dly cycles after ena, hold run_len cycles, then present rd_val.
   initial begin
      m_busy    = 1'b0;
      m_data_rd = '0;
      forever begin
         @(negedge I2C_clock);
         if (m_ena && !m_busy) begin
            repeat (rise_dly - 1) @(negedge I2C_clock);
            if (hang) begin
               while (m_ena) @(negedge I2C_clock);
            end else begin
               m_busy = 1'b1;
               repeat (run_len) @(negedge I2C_clock);
               m_data_rd = rd_val;
               m_busy    = 1'b0;
            end
         end
      end
   end

   // Monitor: all comparisons happen here.
   initial begin
      logic    ena_q, busy_q, fall_pend;
      int      cyc, last_fall;
      chk_t    c;
      launch_t l;
      done_t   d;
      ena_q = 1'b0; busy_q = 1'b0; fall_pend = 1'b0; cyc = 0; last_fall = 0;
      forever begin
         @(negedge I2C_clock);
         cyc++;
         while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            check(c.name, c.act, c.exp);
         end
         if (reset_n) begin
            if (m_ena && !ena_q) begin
               if (launch_q.size() == 0) check("launch_unexpected", 32'd1, 32'd0);
               else begin
                  l = launch_q.pop_front();
                  check("launch_fields", {8'h0, m_addr, m_rw, m_data_wr}, {8'h0, l.addr, l.rw, l.data});
               end
               if (fall_pend) begin
                  check("bus_gap_ok", 32'((cyc - last_fall - 1) >= int'(GAP)), 32'd1);
                  fall_pend = 1'b0;
               end
            end
            if (|done) begin
               if (done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
               else begin
                  d = done_q.pop_front();
                  check("done_onehot", 32'(done), 32'd1 << d.idx);
                  check("done_err", 32'(err), d.er ? (32'd1 << d.idx) : 32'd0);
                  check("done_rd_data", 32'(rd_data), 32'(d.rd));
               end
            end else if (|err) begin
               check("err_without_done", 32'(err), 32'd0);
            end
         end
         if (busy_q && !m_busy) begin
            last_fall = cyc;
            fall_pend = 1'b1;
         end
         ena_q  = m_ena;
         busy_q = m_busy;
      end
   end

   task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_q.push_back(chk_t'{name: name, act: act, exp: exp});
   endtask

   task automatic expect_txn(input int i, input logic rw, input logic er, input logic [15:0] rd);
      launch_q.push_back(launch_t'{addr: ADDR[i], rw: rw, data: DATA[i]});
      done_q.push_back(done_t'{idx: i, er: er, rd: rd});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge I2C_clock);
   endtask

   task automatic wait_done(input int i, input int budget);
      bit ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge I2C_clock);
         if (done[i]) ok = 1'b1;
      end
      if (!ok) push_chk("wait_done_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_any_done(input int budget);
      bit ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge I2C_clock);
         if (|done) ok = 1'b1;
      end
      if (!ok) push_chk("wait_any_done_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge I2C_clock);
         if (!arb_busy) ok = 1'b1;
      end
      if (!ok) push_chk("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_level(input bit want_ena, input logic lvl, input int budget);
      bit ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge I2C_clock);
         if ((want_ena ? m_ena : m_busy) == lvl) ok = 1'b1;
      end
      if (!ok) push_chk("wait_level_timeout", 32'd1, 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      push_chk({tag, "_done"},      32'(done),      32'd0);
      push_chk({tag, "_err"},       32'(err),       32'd0);
      push_chk({tag, "_rd_data"},   32'(rd_data),   32'd0);
      push_chk({tag, "_m_ena"},     32'(m_ena),     32'd0);
      push_chk({tag, "_m_addr"},    32'(m_addr),    32'd0);
      push_chk({tag, "_m_rw"},      32'(m_rw),      32'd0);
      push_chk({tag, "_m_data_wr"}, 32'(m_data_wr), 32'd0);
      push_chk({tag, "_arb_busy"},  32'(arb_busy),  32'd0);
   endtask

   initial begin
      int n;
      reset_n  = 1'b0;
      req      = '0;
      req_rw   = 4'b0100;
      req_addr = {ADDR[3], ADDR[2], ADDR[1], ADDR[0]};
      req_data = {DATA[3], DATA[2], DATA[1], DATA[0]};
      rise_dly = 4;
      run_len  = 120;
      rd_val   = '0;
      hang     = 1'b0;
      tick(3);
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick(2);

      // single write; rd_data stays at its reset value
      expect_txn(0, 1'b0, 1'b0, 16'h0000);
      req[0] = 1'b1;
      tick(1);
      push_chk("grant_latency", 32'(m_ena), 32'd1);
      wait_done(0, 400);
      req[0] = 1'b0;
      wait_idle(100);

      // read
      rd_val = 16'h1234;
      expect_txn(2, 1'b1, 1'b0, 16'h1234);
      req[2] = 1'b1;
      wait_done(2, 400);
      req[2] = 1'b0;
      wait_idle(100);

      // write leaves the last read result in place
      expect_txn(1, 1'b0, 1'b0, 16'h1234);
      req[1] = 1'b1;
      wait_done(1, 400);
      req[1] = 1'b0;
      wait_idle(100);

      // contention held from reset: order 0,1,3,0,1,3
      reset_n = 1'b0;
      req     = 4'b1011;
      tick(2);
      for (int k = 0; k < 6; k++) begin
         n = (k % 3 == 2) ? 3 : k % 3;
         expect_txn(n, 1'b0, 1'b0, 16'h0000);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) wait_any_done(400);
      req = '0;
      wait_idle(100);

      // launch timeout on requester 1, then requester 2 served normally
      hang   = 1'b1;
      rd_val = 16'hBEEF;
      expect_txn(1, 1'b0, 1'b1, 16'h0000);
      expect_txn(2, 1'b1, 1'b0, 16'hBEEF);
      req = 4'b0110;
      wait_level(1'b1, 1'b1, 50);
      n = 0;
      while (m_ena && n < 5000) begin
         n++;
         @(negedge I2C_clock);
      end
      push_chk("launch_timeout_len", 32'(n), 32'(TMO));
      req[1] = 1'b0;
      hang   = 1'b0;
      wait_done(2, 400);
      req[2] = 1'b0;
      wait_idle(100);

      // reset during RUN: no completion, all outputs cleared
      launch_q.push_back(launch_t'{addr: ADDR[3], rw: 1'b0, data: DATA[3]});
      req[3] = 1'b1;
      wait_level(1'b0, 1'b1, 30);
      tick(10);
      reset_n = 1'b0;
      req     = '0;
      tick(1);
      chk_all_zero("mid_reset");
      reset_n = 1'b1;
      wait_level(1'b0, 1'b0, 200);
      tick(20);

      // fresh request after reset
      req_rw[3] = 1'b1;
      rd_val    = 16'h7777;
      expect_txn(3, 1'b1, 1'b0, 16'h7777);
      req[3] = 1'b1;
      wait_done(3, 400);
      req[3] = 1'b0;
      wait_idle(100);

      tick(3);
      push_chk("launch_q_empty", 32'(launch_q.size()), 32'd0);
      push_chk("done_q_empty", 32'(done_q.size()), 32'd0);
      tick(3);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
